// File: rtl/seg_readback_pkg.sv
// Shared constants and types for the seven-segment readback path.
// Pattern table is active-high: bit7=a ... bit1=g, bit0=dp.
package seg_readback_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEG_DP     = 0;

    localparam logic [7:0] BLANK_PAT = 8'h00;
    localparam logic [7:0] DP_MASK   = ~(8'h01 << SEG_DP);

    // Index i holds the lit-segment pattern for hex digit i.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,
        8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66,
        8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Active-low segment pins to hex digit, blank and illegal flags.
// Decimal point never takes part in the match.
module seg7_decode
    import seg_readback_pkg::*;
(
    input  logic [7:0] seg,
    output dec_t       dec
);

    logic [7:0] p;
    logic       hit;

    always_comb begin
        p   = ~seg & DP_MASK;
        hit = 1'b0;
        dec = '0;
        for (int i = 0; i < 16; i++) begin
            if (p == SEG_TABLE[i]) begin
                dec.digit = 4'(i);
                hit       = 1'b1;
            end
        end
        if (p == BLANK_PAT) begin
            dec.blank = 1'b1;
        end else if (!hit) begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/seg_readback.sv
// Scans eight segment buses, decodes them and publishes a value
// once it has been identical across STABLE_SCANS clean scans.
module seg_readback
    import seg_readback_pkg::*;
#(
    parameter int STABLE_SCANS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  seg0,
    input  logic [7:0]  seg1,
    input  logic [7:0]  seg2,
    input  logic [7:0]  seg3,
    input  logic [7:0]  seg4,
    input  logic [7:0]  seg5,
    input  logic [7:0]  seg6,
    input  logic [7:0]  seg7,
    output logic [31:0] value,
    output logic [7:0]  blank,
    output logic [7:0]  err,
    output logic        upd,
    output logic        scan_done
);

    localparam int DW = NUM_DIGITS * 4;
    localparam logic [3:0] ST = 4'(STABLE_SCANS);

    logic [2:0]    idx;
    logic [7:0]    cur;
    dec_t          dec;

    logic [DW-1:0] sdig;
    logic [7:0]    sblk;
    logic [7:0]    serr;

    logic [DW+7:0] prev;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;

    logic [DW-1:0] full_dig;
    logic [7:0]    full_blk;
    logic [7:0]    full_err;

    logic [DW-1:0] value_q;
    logic [7:0]    blank_q;
    logic [7:0]    err_q;
    logic          upd_q;
    logic          sd_q;

    logic          last;
    logic          commit;

    always_comb begin
        cur = '0;
        unique case (idx)
            3'd0: cur = seg0;
            3'd1: cur = seg1;
            3'd2: cur = seg2;
            3'd3: cur = seg3;
            3'd4: cur = seg4;
            3'd5: cur = seg5;
            3'd6: cur = seg6;
            3'd7: cur = seg7;
        endcase
    end

    seg7_decode u_dec (
        .seg (cur),
        .dec (dec)
    );

    // Completed scan view: slot 7 comes straight from the decoder.
    assign full_dig = {dec.digit, sdig[DW-5:0]};
    assign full_blk = {dec.blank, sblk[6:0]};
    assign full_err = {dec.illegal, serr[6:0]};

    assign last = en && (idx == 3'd7);

    always_comb begin
        cnt_nxt = cnt;
        if (|full_err) begin
            cnt_nxt = '0;
        end else if ({full_dig, full_blk} == prev) begin
            cnt_nxt = (cnt >= ST) ? ST : cnt + 4'd1;
        end else begin
            cnt_nxt = 4'd1;
        end
    end

    // Stability is judged once per scan; the load happens on a later edge.
    assign commit = en && (cnt == ST)
                 && (prev != {value_q, blank_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            sdig    <= '0;
            sblk    <= '0;
            serr    <= '0;
            prev    <= '0;
            cnt     <= '0;
            value_q <= '0;
            blank_q <= '0;
            err_q   <= '0;
            upd_q   <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            upd_q <= commit;
            sd_q  <= last;
            if (en) begin
                idx                   <= idx + 3'd1;
                sdig[{idx, 2'b00} +: 4] <= dec.digit;
                sblk[idx]             <= dec.blank;
                serr[idx]             <= dec.illegal;
            end
            if (last) begin
                err_q <= full_err;
                cnt   <= cnt_nxt;
                prev  <= {full_dig, full_blk};
            end
            if (commit) begin
                {value_q, blank_q} <= prev;
            end
        end
    end

    assign value     = value_q;
    assign blank     = blank_q;
    assign err       = err_q;
    assign upd       = upd_q & en;
    assign scan_done = sd_q & en;

endmodule

// File: tb/tb_seg_readback.sv
// Directed bench for seg_readback with hand-computed pin patterns.
module tb_seg_readback;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [7:0]  s [8];
    logic [31:0] value;
    logic [7:0]  blank;
    logic [7:0]  err;
    logic        upd;
    logic        scan_done;

    int errors = 0;
    int checks = 0;
    int nu;
    int ns;
    int n5;

    seg_readback #(.STABLE_SCANS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seg0      (s[0]),
        .seg1      (s[1]),
        .seg2      (s[2]),
        .seg3      (s[3]),
        .seg4      (s[4]),
        .seg5      (s[5]),
        .seg6      (s[6]),
        .seg7      (s[7]),
        .value     (value),
        .blank     (blank),
        .err       (err),
        .upd       (upd),
        .scan_done (scan_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pin(input logic [3:0] d);
        logic [7:0] r;
        case (d)
            4'h0: r = 8'h03;
            4'h1: r = 8'h9F;
            4'h2: r = 8'h25;
            4'h3: r = 8'h0D;
            4'h4: r = 8'h99;
            4'h5: r = 8'h49;
            4'h6: r = 8'h41;
            4'h7: r = 8'h1F;
            4'h8: r = 8'h01;
            4'h9: r = 8'h09;
            4'hA: r = 8'h11;
            4'hB: r = 8'hC1;
            4'hC: r = 8'h63;
            4'hD: r = 8'h85;
            4'hE: r = 8'h61;
            default: r = 8'h71;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        nu = 0;
        ns = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) nu++;
            if (scan_done === 1'b1) ns++;
        end
    endtask

    task automatic set_val(input logic [31:0] v, input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            s[i] = b[i] ? 8'hFF : pin(v[4*i +: 4]);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) s[i] = 8'hFF;
        #12;
        chk("rst value", value, 32'h0);
        chk("rst blank", blank, 32'h0);
        chk("rst err", err, 32'h0);
        chk("rst upd", upd, 32'h0);
        chk("rst scan_done", scan_done, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;

        // idle display: all dark
        step(16);
        chk("t1 early upd", nu, 0);
        chk("t1 scans", ns, 2);
        step(1);
        chk("t1 upd", upd, 32'h1);
        chk("t1 value", value, 32'h0);
        chk("t1 blank", blank, 32'hFF);
        chk("t1 err", err, 32'h0);
        step(7);
        chk("t1 settle upd", nu, 0);

        // static value
        set_val(32'h12345678, 8'h00);
        step(16);
        chk("t2 early upd", nu, 0);
        chk("t2 scans", ns, 2);
        chk("t2 held", value, 32'h0);
        step(1);
        chk("t2 upd", upd, 32'h1);
        chk("t2 value", value, 32'h12345678);
        chk("t2 blank", blank, 32'h0);
        step(7);
        chk("t2 settle upd", nu, 0);

        // one-scan glitch on digit 3
        s[3] = pin(4'hF);
        step(8);
        chk("t3 glitch upd", nu, 0);
        s[3] = pin(4'h5);
        step(24);
        chk("t3 restore upd", nu, 0);
        chk("t3 value", value, 32'h12345678);

        // illegal pattern on digit 5
        s[5] = 8'hAA;
        step(8);
        chk("t4 err", err, 32'h20);
        chk("t4 scan_done", scan_done, 32'h1);
        chk("t4 value held", value, 32'h12345678);
        s[5] = pin(4'h3);
        step(8);
        chk("t4 err clear", err, 32'h0);
        chk("t4 upd a", nu, 0);
        step(8);
        chk("t4 upd b", nu, 0);

        // dp toggling every cycle
        n5 = 0;
        repeat (24) begin
            for (int i = 0; i < 8; i++) s[i][0] = ~s[i][0];
            step(1);
            n5 += nu;
        end
        chk("t5 upd", n5, 0);
        chk("t5 err", err, 32'h0);
        chk("t5 value", value, 32'h12345678);

        // freeze at idx 4
        step(4);
        en = 1'b0;
        step(10);
        chk("t6 frozen upd", nu, 0);
        chk("t6 frozen scan_done", ns, 0);
        en = 1'b1;
        step(3);
        chk("t6 resume early", ns, 0);
        step(1);
        chk("t6 resume done", scan_done, 32'h1);

        // letters plus a dark top digit
        set_val(32'h0BCDEF09, 8'h80);
        step(16);
        chk("t7 early upd", nu, 0);
        step(1);
        chk("t7 upd", upd, 32'h1);
        chk("t7 value", value, 32'h0BCDEF09);
        chk("t7 blank", blank, 32'h80);

        // async reset mid-scan, between clock edges
        step(3);
        rst = 1'b1;
        #2;
        chk("ar value", value, 32'h0);
        chk("ar blank", blank, 32'h0);
        chk("ar err", err, 32'h0);
        chk("ar upd", upd, 32'h0);
        chk("ar scan_done", scan_done, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
